mem_write_arbiter: RTL and testbench
====================================

MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: port clk (100 MHz system clock) and port rst_n.
REQ-002 Parameter FIRST_PRIO, default 0: requester that wins the first tie after reset.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 calib_done  in  1  memory calibration complete; no grants while low.
REQ-006 reqN_en  in  1  (N=0,1) burst request, held until reqN_done.
REQ-007 reqN_addr  in  30  byte address, word-aligned, stable while reqN_en is high.
REQ-008 reqN_bl  in  6  burst length minus 1 (1..64 words), stable while reqN_en is high.
REQ-009 reqN_data / reqN_mask  in  32 / 4  current write word and byte mask.
REQ-010 reqN_data_rd  out  1  current word consumed this cycle; requester advances to the next word.
REQ-011 reqN_done  out  1  one-cycle pulse when the burst command has been accepted.
REQ-012 mem_cmd_en, mem_cmd_instr[2:0], mem_cmd_bl[5:0], mem_cmd_byte_addr[29:0]  out  memory port command signals.
REQ-013 mem_cmd_full  in  1  memory port command FIFO full.
REQ-014 mem_wr_en, mem_wr_mask[3:0], mem_wr_data[31:0]  out  memory port write FIFO signals.
REQ-015 mem_wr_full, mem_wr_underrun, mem_wr_error  in  1 each  write FIFO status.
REQ-016 err_sticky  out  1  latched write error (see REQ-030).

Function
REQ-017 FSM states: IDLE, DATA, CMD, DONE.
- IDLE -> DATA when calib_done is high and at least one reqN_en is high.
- DATA -> CMD after the last word has been written.
- CMD -> DONE when cmd_en is issued.
- DONE -> IDLE unconditionally.
REQ-018 Arbitration is round-robin.
- When both requesters are pending in IDLE, the winner is the one not granted last; the first tie goes to FIRST_PRIO.
- A single pending requester always wins.
REQ-019 The grant, address and bl are latched on the IDLE->DATA transition and held until DONE; requester inputs are ignored after latching.
REQ-020 DATA state:
- mem_wr_en = !mem_wr_full; data and mask are muxed combinationally from the granted requester.
- reqN_data_rd equals mem_wr_en for the granted requester only.
- A 6-bit word counter increments on each write; DATA exits when the counter equals bl and a write occurs.
REQ-021 CMD state:
- mem_cmd_en = !mem_cmd_full, with mem_cmd_instr=3'b000, mem_cmd_bl=latched bl, mem_cmd_byte_addr=latched addr.
- The command is never issued before all bl+1 words are in the FIFO.
REQ-022 reqN_done pulses in DONE for the granted requester; minimum burst turnaround is bl+4 cycles, including the IDLE cycle.
REQ-023 mem_wr_full held high stalls DATA indefinitely with no write and no data_rd; mem_cmd_full stalls CMD likewise.
REQ-024 Deasserting a request mid-burst does not abort it; the burst completes.
REQ-025 calib_done falling mid-burst does not abort it; only new grants are blocked.
REQ-026 All mem_* and req*_data_rd outputs are 0 outside their states.

Reset
REQ-027 rst_n low asynchronously forces:
- FSM to IDLE;
- word counter to 0;
- last-grant to !FIFO_PRIO-equivalent, so that FIRST_PRIO wins the first tie;
- all outputs to 0, including err_sticky.
REQ-028 Reset asserted mid-burst abandons the burst; no cmd_en is issued afterwards.

Configuration
REQ-029 Macro MEM_ARB_ERR_LATCH_EN selects the error-latch feature.
REQ-030 With MEM_ARB_ERR_LATCH_EN defined:
- err_sticky sets on mem_wr_underrun or mem_wr_error and clears only on reset;
- while set, no new grants are issued.
REQ-031 Without MEM_ARB_ERR_LATCH_EN, err_sticky is tied 0 and error inputs are ignored.

Structure
REQ-032 The shared definitions header holds:
- the MCB command encodings (WRITE=3'b000, READ=3'b001);
- the FSM state constants;
- the address and burst-length widths (30 and 6).
REQ-033 One sub-module, rr_arbiter2: 2-way round-robin grant with last-grant register.

Verification
REQ-034 Single request: req0_en with bl=3 and addr=0x100, FIFOs never full -> 4 mem_wr_en cycles, then cmd_en with bl=3 and addr=0x100, then req0_done, total 7 cycles.
REQ-035 Simultaneous requests, both asserted continuously for 3 bursts, FIRST_PRIO=0 -> grant order 0,1,0 with no overlap of data between requesters.
REQ-036 Backpressure: mem_wr_full high for 5 cycles mid-burst, then mem_cmd_full high for 3 cycles -> no lost or duplicated words; the command issues only after mem_cmd_full drops.
REQ-037 Reset mid-DATA after 2 of 8 words -> outputs 0 immediately, no cmd_en; after release, a fresh request is granted normally.
REQ-038 calib_done=0 with req1_en high -> no grant; after calib_done rises, the grant occurs on the next cycle.
REQ-039 With MEM_ARB_ERR_LATCH_EN, pulse mem_wr_error -> err_sticky=1 and a subsequent request is never granted; without the macro, err_sticky stays 0 and the request is served.

Source files
------------

// File: rtl/mem_write_arbiter_pkg.sv
// Shared encodings, widths and FSM state type for the two-requester memory write arbiter.
package mem_write_arbiter_pkg;

    localparam int ADDR_W = 30;
    localparam int BL_W   = 6;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CMD  = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant register advances only when the grant is accepted.
module rr_arbiter2 #(
    parameter int FIRST_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_gnt,
    output logic       o_valid
);

    logic r_last;

    always_comb begin
        o_valid = |i_req;
        if (i_req == 2'b11) begin
            o_gnt = ~r_last;
        end else begin
            o_gnt = i_req[1];
        end
    end

    // Reset to the opposite of FIRST_PRIO so that requester wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= (FIRST_PRIO == 0);
        end else if (i_accept) begin
            r_last <= o_gnt;
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates two burst-write requesters onto one MCB-style write port (data first, then command).
// Optional sticky write-error latch blocking new grants: define MEM_ARB_ERR_LATCH_EN.
//
// state   | meaning
// IDLE    | waiting for calib_done and a pending request; arbitrate and latch burst
// DATA    | stream bl+1 words from the granted requester into the write FIFO
// CMD     | issue the write command once the command FIFO has room
// DONE    | one-cycle done pulse to the granted requester
module mem_write_arbiter
    import mem_write_arbiter_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              calib_done,
    input  logic              req0_en,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [BL_W-1:0]   req0_bl,
    input  logic [31:0]       req0_data,
    input  logic [3:0]        req0_mask,
    output logic              req0_data_rd,
    output logic              req0_done,
    input  logic              req1_en,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [BL_W-1:0]   req1_bl,
    input  logic [31:0]       req1_data,
    input  logic [3:0]        req1_mask,
    output logic              req1_data_rd,
    output logic              req1_done,
    output logic              mem_cmd_en,
    output logic [2:0]        mem_cmd_instr,
    output logic [BL_W-1:0]   mem_cmd_bl,
    output logic [ADDR_W-1:0] mem_cmd_byte_addr,
    input  logic              mem_cmd_full,
    output logic              mem_wr_en,
    output logic [3:0]        mem_wr_mask,
    output logic [31:0]       mem_wr_data,
    input  logic              mem_wr_full,
    input  logic              mem_wr_underrun,
    input  logic              mem_wr_error,
    output logic              err_sticky
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic [BL_W-1:0]   r_bl;
    logic [BL_W-1:0]   r_word_cnt;
    logic              w_arb_gnt;
    logic              w_arb_valid;
    logic              w_start;
    logic              w_wr_fire;
    logic              w_last_word;
    logic              w_err_block;

    rr_arbiter2 #(
        .FIRST_PRIO(FIRST_PRIO)
    ) u_rr_arbiter2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   ({req1_en, req0_en}),
        .i_accept(w_start),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    assign w_start     = (r_state == ST_IDLE) && calib_done && w_arb_valid && !w_err_block;
    assign w_wr_fire   = (r_state == ST_DATA) && !mem_wr_full;
    assign w_last_word = (r_word_cnt == r_bl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        mem_wr_en         = 1'b0;
        mem_wr_mask       = '0;
        mem_wr_data       = '0;
        mem_cmd_en        = 1'b0;
        mem_cmd_instr     = '0;
        mem_cmd_bl        = '0;
        mem_cmd_byte_addr = '0;
        req0_data_rd      = 1'b0;
        req1_data_rd      = 1'b0;
        req0_done         = 1'b0;
        req1_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                mem_wr_en    = w_wr_fire;
                mem_wr_mask  = r_gnt ? req1_mask : req0_mask;
                mem_wr_data  = r_gnt ? req1_data : req0_data;
                req0_data_rd = w_wr_fire && !r_gnt;
                req1_data_rd = w_wr_fire && r_gnt;
                if (w_wr_fire && w_last_word) w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                mem_cmd_en        = !mem_cmd_full;
                mem_cmd_instr     = CMD_WRITE;
                mem_cmd_bl        = r_bl;
                mem_cmd_byte_addr = r_addr;
                if (!mem_cmd_full) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                req0_done   = !r_gnt;
                req1_done   = r_gnt;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Burst parameters are captured once at grant; requester pins are don't-care afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt  <= 1'b0;
            r_addr <= '0;
            r_bl   <= '0;
        end else if (w_start) begin
            r_gnt  <= w_arb_gnt;
            r_addr <= w_arb_gnt ? req1_addr : req0_addr;
            r_bl   <= w_arb_gnt ? req1_bl : req0_bl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if (w_start) begin
            r_word_cnt <= '0;
        end else if (w_wr_fire) begin
            r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
        end
    end

`ifdef MEM_ARB_ERR_LATCH_EN
    logic r_err_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (mem_wr_underrun || mem_wr_error) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky  = r_err_sticky;
    assign w_err_block = r_err_sticky;
`else
    logic w_unused_err;

    assign w_unused_err = mem_wr_underrun | mem_wr_error;
    assign err_sticky   = 1'b0;
    assign w_err_block  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Randomized bench for mem_write_arbiter against a burst-level reference model.
module tb_mem_write_arbiter;

    localparam int TB_FIRST_PRIO = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        calib_done;
    logic        req0_en, req1_en;
    logic [29:0] req0_addr, req1_addr;
    logic [5:0]  req0_bl, req1_bl;
    logic [31:0] req0_data, req1_data;
    logic [3:0]  req0_mask, req1_mask;
    logic        req0_data_rd, req1_data_rd, req0_done, req1_done;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_wr_full, mem_wr_underrun, mem_wr_error, err_sticky;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_write_arbiter #(.FIRST_PRIO(TB_FIRST_PRIO)) dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
        .req0_en(req0_en), .req0_addr(req0_addr), .req0_bl(req0_bl), .req0_data(req0_data),
        .req0_mask(req0_mask), .req0_data_rd(req0_data_rd), .req0_done(req0_done),
        .req1_en(req1_en), .req1_addr(req1_addr), .req1_bl(req1_bl), .req1_data(req1_data),
        .req1_mask(req1_mask), .req1_data_rd(req1_data_rd), .req1_done(req1_done),
        .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
        .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full),
        .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data),
        .mem_wr_full(mem_wr_full), .mem_wr_underrun(mem_wr_underrun), .mem_wr_error(mem_wr_error),
        .err_sticky(err_sticky)
    );

    // requester agents
    logic        rq_active [2];
    logic        rq_dropped[2];
    logic        rq_got_rd [2];
    int          rq_idx    [2];
    int          rq_gap    [2];
    int          rq_left   [2];
    logic [29:0] rq_addr   [2];
    logic [5:0]  rq_bl     [2];
    logic [35:0] rq_words  [2][64];
    logic        seen_rd   [2];
    logic        seen_done [2];
    int max_gap, max_bl, wr_full_pct, cmd_full_pct, drop_pct, calib_low_pct;
    logic err_pulse;
    int win_rd0, win_rd1;

    // reference model: one burst in flight, counted in words and command
    logic        m_busy, m_gnt, m_last, m_err, m_cmd_pending, m_stalled;
    int          m_words_left, m_idx, m_grant_cyc, m_last_turn, cyc;
    logic [29:0] m_addr;
    logic [5:0]  m_bl;
    logic [35:0] m_words[64];
    int          grants[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic load_burst(input int n, input logic [29:0] addr, input logic [5:0] bl);
        rq_active[n]  = 1'b1;
        rq_dropped[n] = 1'b0;
        rq_got_rd[n]  = 1'b0;
        rq_idx[n]     = 0;
        rq_addr[n]    = addr;
        rq_bl[n]      = bl;
        for (int i = 0; i < 64; i++) rq_words[n][i] = {4'($urandom), 32'($urandom)};
    endtask

    task automatic drive_pins();
        logic [35:0] w0, w1;
        w0 = rq_words[0][rq_idx[0] % 64];
        w1 = rq_words[1][rq_idx[1] % 64];
        req0_en   = rq_active[0] && !rq_dropped[0];
        req1_en   = rq_active[1] && !rq_dropped[1];
        req0_addr = rq_dropped[0] ? 30'($urandom) : rq_addr[0];
        req1_addr = rq_dropped[1] ? 30'($urandom) : rq_addr[1];
        req0_bl   = rq_dropped[0] ? 6'($urandom) : rq_bl[0];
        req1_bl   = rq_dropped[1] ? 6'($urandom) : rq_bl[1];
        req0_data = w0[31:0];
        req0_mask = w0[35:32];
        req1_data = w1[31:0];
        req1_mask = w1[35:32];
    endtask

    task automatic update_requesters();
        logic [29:0] a;
        for (int n = 0; n < 2; n++) begin
            if (seen_done[n]) begin
                rq_active[n] = 1'b0;
                rq_gap[n]    = int'($urandom_range(max_gap, 0));
            end else if (seen_rd[n]) begin
                rq_idx[n]++;
                rq_got_rd[n] = 1'b1;
            end
            if (!rq_active[n] && rq_left[n] > 0) begin
                if (rq_gap[n] > 0) begin
                    rq_gap[n]--;
                end else begin
                    rq_left[n]--;
                    a = 30'($urandom);
                    a[1:0] = 2'b00;
                    load_burst(n, a, 6'($urandom_range(max_bl, 0)));
                end
            end
            if (rq_active[n] && rq_got_rd[n] && !rq_dropped[n] && int'($urandom_range(99, 0)) < drop_pct)
                rq_dropped[n] = 1'b1;
        end
        mem_wr_full     = int'($urandom_range(99, 0)) < wr_full_pct;
        mem_cmd_full    = int'($urandom_range(99, 0)) < cmd_full_pct;
        calib_done      = !(int'($urandom_range(99, 0)) < calib_low_pct);
        mem_wr_error    = err_pulse;
        mem_wr_underrun = 1'b0;
        err_pulse       = 1'b0;
    endtask

    task automatic monitor();
        logic exp_wr, exp_cmd, exp_done, was_idle, w;
        cyc++;
        was_idle = !m_busy;
        exp_wr   = m_busy && (m_words_left > 0) && !mem_wr_full;
        exp_cmd  = m_busy && (m_words_left == 0) && m_cmd_pending && !mem_cmd_full;
        exp_done = m_busy && !m_cmd_pending;
        check_val("wr_en", 64'(mem_wr_en), 64'(exp_wr));
        check_val("data_rd0", 64'(req0_data_rd), 64'(exp_wr && !m_gnt));
        check_val("data_rd1", 64'(req1_data_rd), 64'(exp_wr && m_gnt));
        check_val("cmd_en", 64'(mem_cmd_en), 64'(exp_cmd));
        check_val("done0", 64'(req0_done), 64'(exp_done && !m_gnt));
        check_val("done1", 64'(req1_done), 64'(exp_done && m_gnt));
        check_val("err_sticky", 64'(err_sticky), 64'(m_err));
        if (was_idle) check_val("idle_bus", 64'({mem_cmd_byte_addr, mem_wr_data}), 64'(0));
        if (exp_wr) begin
            check_val("wr_word", 64'({mem_wr_mask, mem_wr_data}), 64'(m_words[m_idx]));
            m_idx++;
            m_words_left--;
        end else if (m_busy && m_words_left > 0) begin
            m_stalled = 1'b1;
        end
        if (exp_cmd) begin
            check_val("cmd_instr", 64'(mem_cmd_instr), 64'(3'b000));
            check_val("cmd_bl", 64'(mem_cmd_bl), 64'(m_bl));
            check_val("cmd_addr", 64'(mem_cmd_byte_addr), 64'(m_addr));
            m_cmd_pending = 1'b0;
        end else if (m_busy && m_words_left == 0 && m_cmd_pending) begin
            m_stalled = 1'b1;
        end
        if (exp_done) begin
            m_last_turn = cyc - m_grant_cyc + 1;
            if (!m_stalled) check_val("turnaround", 64'(m_last_turn), 64'(m_bl + 4));
            m_busy = 1'b0;
        end
        if (was_idle && calib_done && (req0_en || req1_en) && !m_err) begin
            w = (req0_en && req1_en) ? !m_last : req1_en;
            m_last        = w;
            m_gnt         = w;
            m_addr        = rq_addr[w];
            m_bl          = rq_bl[w];
            for (int i = 0; i < 64; i++) m_words[i] = rq_words[w][i];
            m_words_left  = int'(m_bl) + 1;
            m_cmd_pending = 1'b1;
            m_idx         = 0;
            m_grant_cyc   = cyc;
            m_stalled     = 1'b0;
            m_busy        = 1'b1;
            grants.push_back(int'(w));
        end
`ifdef MEM_ARB_ERR_LATCH_EN
        if (mem_wr_underrun || mem_wr_error) m_err = 1'b1;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        update_requesters();
        drive_pins();
        @(negedge clk);
        seen_rd[0]   = req0_data_rd;
        seen_rd[1]   = req1_data_rd;
        seen_done[0] = req0_done;
        seen_done[1] = req1_done;
        win_rd0 += int'(req0_data_rd);
        win_rd1 += int'(req1_data_rd);
        monitor();
    endtask

    task automatic reset_model();
        m_busy = 1'b0; m_gnt = 1'b0; m_err = 1'b0; m_cmd_pending = 1'b0; m_stalled = 1'b0;
        m_last = (TB_FIRST_PRIO == 0);
        m_words_left = 0; m_idx = 0;
        grants.delete();
        for (int n = 0; n < 2; n++) begin
            rq_active[n] = 1'b0; rq_dropped[n] = 1'b0; rq_got_rd[n] = 1'b0;
            rq_idx[n] = 0; rq_gap[n] = 0; rq_left[n] = 0;
            seen_rd[n] = 1'b0; seen_done[n] = 1'b0;
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_ctrl", 64'({mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_wr_en, mem_wr_mask,
                                   req0_data_rd, req1_data_rd, req0_done, req1_done, err_sticky}), 64'(0));
        check_val("rst_bus", 64'({mem_cmd_byte_addr, mem_wr_data}), 64'(0));
        reset_model();
        drive_pins();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((m_busy || rq_active[0] || rq_active[1] || rq_left[0] > 0 || rq_left[1] > 0) && n < budget) begin
            step();
            n++;
        end
        check_val({tag, "_timeout"}, 64'(n >= budget), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        calib_done = 1'b1; mem_wr_full = 1'b0; mem_cmd_full = 1'b0;
        mem_wr_underrun = 1'b0; mem_wr_error = 1'b0; err_pulse = 1'b0;
        max_gap = 0; max_bl = 0; wr_full_pct = 0; cmd_full_pct = 0; drop_pct = 0; calib_low_pct = 0;
        cyc = 0; m_last_turn = 0; m_grant_cyc = 0; m_addr = '0; m_bl = '0;
        for (int i = 0; i < 64; i++) m_words[i] = '0;
        for (int n = 0; n < 2; n++) for (int i = 0; i < 64; i++) rq_words[n][i] = '0;
        rq_addr[0] = '0; rq_addr[1] = '0; rq_bl[0] = '0; rq_bl[1] = '0;
        reset_model();
        drive_pins();
        do_reset();

        // single burst, bl=3 at 0x100: grant + 4 words + cmd + done = 7 cycles
        load_burst(0, 30'h100, 6'd3);
        drain("single", 100);
        check_val("single_turnaround", 64'(m_last_turn), 64'(7));

        // both requesters continuously pending from reset: alternate starting with FIRST_PRIO
        do_reset();
        max_bl = 3;
        rq_left[0] = 2;
        rq_left[1] = 2;
        drain("tie", 300);
        exp_order = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++)
            check_val("tie_order", 64'((i < grants.size()) ? grants[i] : 9), 64'(exp_order[i]));

        // write-FIFO full for 5 cycles mid-burst, then command FIFO full for 3 cycles
        load_burst(0, 30'h2A0, 6'd7);
        for (int i = 0; i < 50 && !(m_busy && m_words_left == 5); i++) step();
        wr_full_pct = 100;
        repeat (5) step();
        wr_full_pct = 0;
        for (int i = 0; i < 50 && !(m_busy && m_words_left == 0 && m_cmd_pending); i++) step();
        cmd_full_pct = 100;
        repeat (3) step();
        cmd_full_pct = 0;
        drain("bp", 100);
        check_val("bp_turnaround", 64'(m_last_turn), 64'(19));

        // reset after 2 of 8 words, then a fresh request from requester 1
        load_burst(0, 30'h400, 6'd7);
        for (int i = 0; i < 50 && !(m_busy && m_words_left == 6); i++) step();
        do_reset();
        repeat (4) step();
        load_burst(1, 30'h1F0, 6'd2);
        drain("post_rst", 100);
        check_val("post_rst_grant", 64'((grants.size() > 0) ? grants[0] : 9), 64'(1));

        // no grant while calibration is pending; grant on the first cycle calib_done is seen
        calib_low_pct = 100;
        load_burst(1, 30'h80, 6'd1);
        win_rd1 = 0;
        repeat (6) step();
        check_val("calib_no_rd", 64'(win_rd1), 64'(0));
        calib_low_pct = 0;
        step();
        step();
        check_val("calib_grant_next", 64'(req1_data_rd), 64'(1));
        drain("calib", 100);

        // randomized traffic with backpressure, request drops and calibration glitches
        do_reset();
        max_gap = 3; max_bl = 15;
        wr_full_pct = 20; cmd_full_pct = 25; drop_pct = 30; calib_low_pct = 10;
        rq_left[0] = 10;
        rq_left[1] = 10;
        drain("random", 4000);
        wr_full_pct = 0; cmd_full_pct = 0; drop_pct = 0; calib_low_pct = 0;

        // write error pulse followed by a request
        do_reset();
        err_pulse = 1'b1;
        step();
        step();
        load_burst(0, 30'h600, 6'd2);
        win_rd0 = 0;
        repeat (20) step();
`ifdef MEM_ARB_ERR_LATCH_EN
        check_val("err_block_rd", 64'(win_rd0), 64'(0));
        check_val("err_set", 64'(err_sticky), 64'(1));
`else
        check_val("err_ignored_rd", 64'(win_rd0), 64'(3));
        check_val("err_tied", 64'(err_sticky), 64'(0));
`endif
        do_reset();
        step();
        check_val("err_cleared", 64'(err_sticky), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
